// File: rtl/rx_detector.sv
// Integrate-and-dump receiver: sums SAMPLES_PER_SYM channel samples and emits a hard +1/-1 decision.
// Optional error counter against a reference symbol is enabled by `define RX_ERR_COUNT_EN.
//   state  | meaning
//   IDLE   | no samples of the current symbol captured yet
//   ACCUM  | partial symbol in the accumulator
//   DECIDE | decision outputs valid this cycle; a capture here starts the next symbol
module rx_detector #(
    parameter  int DATA_W          = 12,
    parameter  int SAMPLES_PER_SYM = 4,
    localparam int ACC_W           = DATA_W + $clog2(SAMPLES_PER_SYM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chan_done,
    input  logic signed [DATA_W-1:0] chan_out,
    input  logic                    rx_clear,
`ifdef RX_ERR_COUNT_EN
    input  logic signed [1:0]       ref_symbol,
    output logic [15:0]             err_count,
`endif
    output logic                    rx_valid,
    output logic                    rx_bit,
    output logic signed [1:0]       rx_symbol,
    output logic signed [ACC_W-1:0] rx_metric,
    output logic [6:0]              sample_cnt
);

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;

    localparam logic [6:0] SPS = 7'(SAMPLES_PER_SYM);

    state_t                  state_q, state_d;
    logic                    done_q, done_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [6:0]              cnt_q, cnt_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_bit_q, rx_bit_d;
    logic signed [1:0]       rx_symbol_q, rx_symbol_d;
    logic signed [ACC_W-1:0] rx_metric_q, rx_metric_d;

    logic                    capture;
    logic signed [ACC_W-1:0] sample_ext, acc_sum;
    logic [6:0]              cnt_inc;

    assign capture    = chan_done & ~done_q;
    assign sample_ext = ACC_W'(chan_out);
    assign done_d     = chan_done;

    // The decision is registered on the edge that captures the final sample, so the
    // outputs are already valid during the single DECIDE cycle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        rx_valid_d  = 1'b0;
        rx_bit_d    = rx_bit_q;
        rx_symbol_d = rx_symbol_q;
        rx_metric_d = rx_metric_q;
        acc_sum     = (state_q == ACCUM) ? acc_q + sample_ext : sample_ext;
        cnt_inc     = (state_q == ACCUM) ? cnt_q + 7'd1 : 7'd1;

        if (state_q == DECIDE) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end

        if (rx_clear) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else if (capture) begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
            if (cnt_inc == SPS) begin
                state_d     = DECIDE;
                rx_valid_d  = 1'b1;
                rx_metric_d = acc_sum;
                if (acc_sum != '0) begin
                    rx_bit_d = ~acc_sum[ACC_W-1];
                end
                rx_symbol_d = rx_bit_d ? 2'sb01 : 2'sb11;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            rx_valid_q  <= 1'b0;
            rx_bit_q    <= 1'b0;
            rx_symbol_q <= '0;
            rx_metric_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            rx_valid_q  <= rx_valid_d;
            rx_bit_q    <= rx_bit_d;
            rx_symbol_q <= rx_symbol_d;
            rx_metric_q <= rx_metric_d;
        end
    end

`ifdef RX_ERR_COUNT_EN
    logic [15:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == DECIDE && rx_symbol_q != ref_symbol && err_q != 16'hFFFF) begin
            err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`endif

    assign rx_valid   = rx_valid_q;
    assign rx_bit     = rx_bit_q;
    assign rx_symbol  = rx_symbol_q;
    assign rx_metric  = rx_metric_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_rx_detector.sv
// Scoreboard bench for rx_detector with SAMPLES_PER_SYM=4.
module tb_rx_detector;
    localparam int DATA_W = 12;
    localparam int SPS    = 4;
    localparam int ACC_W  = 14;

    typedef struct {
        logic signed [ACC_W-1:0] metric;
        logic signed [1:0]       sym;
        logic                    bit_v;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    chan_done = 1'b0;
    logic signed [DATA_W-1:0] chan_out = '0;
    logic                    rx_clear = 1'b0;
    logic                    rx_valid;
    logic                    rx_bit;
    logic signed [1:0]       rx_symbol;
    logic signed [ACC_W-1:0] rx_metric;
    logic [6:0]              sample_cnt;
`ifdef RX_ERR_COUNT_EN
    logic signed [1:0]       ref_symbol = 2'sb01;
    logic [15:0]             err_count;
`endif

    rx_detector #(.DATA_W(DATA_W), .SAMPLES_PER_SYM(SPS)) dut (
        .clk(clk),
        .reset(reset),
        .chan_done(chan_done),
        .chan_out(chan_out),
        .rx_clear(rx_clear),
`ifdef RX_ERR_COUNT_EN
        .ref_symbol(ref_symbol),
        .err_count(err_count),
`endif
        .rx_valid(rx_valid),
        .rx_bit(rx_bit),
        .rx_symbol(rx_symbol),
        .rx_metric(rx_metric),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   valid_cnt = 0;
    int   tb_err = 0;
    logic tb_prev_bit = 1'b0;
    exp_t sb[$];

    always @(negedge clk) if (rx_valid === 1'b1) valid_cnt++;

    task automatic push_expect(input int sum);
        exp_t e;
        e.metric = ACC_W'(sum);
        if (sum > 0) tb_prev_bit = 1'b1;
        else if (sum < 0) tb_prev_bit = 1'b0;
        e.bit_v = tb_prev_bit;
        e.sym   = tb_prev_bit ? 2'sb01 : 2'sb11;
        if (e.sym != 2'sb01 && tb_err < 65535) tb_err++;
        sb.push_back(e);
    endtask

    // Returns one time step after the capturing edge.
    task automatic drive_sample(input int v);
        @(posedge clk); #1;
        chan_done = 1'b1;
        chan_out  = DATA_W'(v);
        @(posedge clk); #1;
        chan_done = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        tb_prev_bit = 1'b0;
        tb_err = 0;
        #2;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rx_valid); end
        checks++; if (rx_bit !== 1'b0) begin failures++; $display("FAIL reset_bit got=%0b exp=0", rx_bit); end
        checks++; if (rx_symbol !== 2'sb00) begin failures++; $display("FAIL reset_symbol got=%0d exp=0", rx_symbol); end
        checks++; if (rx_metric !== '0) begin failures++; $display("FAIL reset_metric got=%0d exp=0", rx_metric); end
        checks++; if (sample_cnt !== 7'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", sample_cnt); end
    endtask

    task automatic test_basic;
        exp_t e;
        int   snap;
        snap = valid_cnt;
        push_expect(280);
        drive_sample(100);
        drive_sample(200);
        drive_sample(-50);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (valid_cnt != snap) begin failures++; $display("FAIL early_valid got=%0d exp=%0d", valid_cnt, snap); end
        checks++; if (sample_cnt !== 7'd3) begin failures++; $display("FAIL partial_cnt got=%0d exp=3", sample_cnt); end
        drive_sample(30);
        e = sb.pop_front();
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", rx_valid); end
        checks++; if (rx_metric !== e.metric) begin failures++; $display("FAIL basic_metric got=%0d exp=%0d", rx_metric, e.metric); end
        checks++; if (rx_symbol !== e.sym) begin failures++; $display("FAIL basic_symbol got=%0d exp=%0d", rx_symbol, e.sym); end
        checks++; if (rx_bit !== e.bit_v) begin failures++; $display("FAIL basic_bit got=%0b exp=%0b", rx_bit, e.bit_v); end
        @(posedge clk); #1;
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%0b exp=0", rx_valid); end
        checks++; if (rx_metric !== e.metric) begin failures++; $display("FAIL basic_hold got=%0d exp=%0d", rx_metric, e.metric); end
    endtask

    task automatic test_no_wrap;
        int   vals[2] = '{-2048, 2047};
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            push_expect(4 * vals[s]);
            for (int k = 0; k < SPS; k++) drive_sample(vals[s]);
            e = sb.pop_front();
            checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL wrap_valid[%0d] got=%0b exp=1", s, rx_valid); end
            checks++; if (rx_metric !== e.metric) begin failures++; $display("FAIL wrap_metric[%0d] got=%0d exp=%0d", s, rx_metric, e.metric); end
            checks++; if (rx_symbol !== e.sym) begin failures++; $display("FAIL wrap_symbol[%0d] got=%0d exp=%0d", s, rx_symbol, e.sym); end
            checks++; if (rx_bit !== e.bit_v) begin failures++; $display("FAIL wrap_bit[%0d] got=%0b exp=%0b", s, rx_bit, e.bit_v); end
            @(posedge clk); #1;
            checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL wrap_pulse[%0d] got=%0b exp=0", s, rx_valid); end
`ifdef RX_ERR_COUNT_EN
            checks++; if (err_count !== 16'(tb_err)) begin failures++; $display("FAIL wrap_err[%0d] got=%0d exp=%0d", s, err_count, tb_err); end
`endif
        end
    endtask

    task automatic test_tie;
        exp_t e;
        push_expect(0);
        drive_sample(10);
        drive_sample(-10);
        drive_sample(5);
        drive_sample(-5);
        e = sb.pop_front();
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL tie_valid got=%0b exp=1", rx_valid); end
        checks++; if (rx_metric !== e.metric) begin failures++; $display("FAIL tie_metric got=%0d exp=%0d", rx_metric, e.metric); end
        checks++; if (rx_bit !== e.bit_v) begin failures++; $display("FAIL tie_bit got=%0b exp=%0b", rx_bit, e.bit_v); end
        checks++; if (rx_symbol !== e.sym) begin failures++; $display("FAIL tie_symbol got=%0d exp=%0d", rx_symbol, e.sym); end
        @(posedge clk); #1;
    endtask

    task automatic test_long_level;
        exp_t e;
        int   snap;
        snap = valid_cnt;
        push_expect(2000);
        @(posedge clk); #1;
        chan_done = 1'b1;
        chan_out  = 12'sd500;
        repeat (60) @(posedge clk);
        #1 chan_done = 1'b0;
        checks++; if (sample_cnt !== 7'd1) begin failures++; $display("FAIL level_cnt got=%0d exp=1", sample_cnt); end
        for (int k = 0; k < 3; k++) drive_sample(500);
        e = sb.pop_front();
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL level_valid got=%0b exp=1", rx_valid); end
        checks++; if (rx_metric !== e.metric) begin failures++; $display("FAIL level_metric got=%0d exp=%0d", rx_metric, e.metric); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_cnt != snap + 1) begin failures++; $display("FAIL level_count got=%0d exp=%0d", valid_cnt - snap, 1); end
    endtask

    task automatic test_reset_flush;
        exp_t e;
        int   snap;
        drive_sample(7);
        drive_sample(7);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        tb_prev_bit = 1'b0;
        tb_err = 0;
        checks++; if (rx_metric !== '0) begin failures++; $display("FAIL flush_metric got=%0d exp=0", rx_metric); end
        checks++; if (sample_cnt !== 7'd0) begin failures++; $display("FAIL flush_cnt got=%0d exp=0", sample_cnt); end
        snap = valid_cnt;
        push_expect(-4);
        for (int k = 0; k < SPS; k++) drive_sample(-1);
        e = sb.pop_front();
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL flush_valid got=%0b exp=1", rx_valid); end
        checks++; if (rx_metric !== e.metric) begin failures++; $display("FAIL flush_result got=%0d exp=%0d", rx_metric, e.metric); end
        checks++; if (rx_symbol !== e.sym) begin failures++; $display("FAIL flush_symbol got=%0d exp=%0d", rx_symbol, e.sym); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_cnt != snap + 1) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", valid_cnt - snap, 1); end
`ifdef RX_ERR_COUNT_EN
        checks++; if (err_count !== 16'(tb_err)) begin failures++; $display("FAIL flush_err got=%0d exp=%0d", err_count, tb_err); end
`endif
    endtask

    task automatic test_clear;
        exp_t e;
        int   snap;
        drive_sample(9);
        drive_sample(9);
        @(posedge clk); #1;
        rx_clear  = 1'b1;
        chan_done = 1'b1;
        chan_out  = 12'sd300;
        @(posedge clk); #1;
        rx_clear  = 1'b0;
        chan_done = 1'b0;
        checks++; if (sample_cnt !== 7'd0) begin failures++; $display("FAIL clear_cnt got=%0d exp=0", sample_cnt); end
        snap = valid_cnt;
        push_expect(-4);
        for (int k = 0; k < SPS; k++) drive_sample(-1);
        e = sb.pop_front();
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL clear_valid got=%0b exp=1", rx_valid); end
        checks++; if (rx_metric !== e.metric) begin failures++; $display("FAIL clear_metric got=%0d exp=%0d", rx_metric, e.metric); end
        checks++; if (rx_bit !== e.bit_v) begin failures++; $display("FAIL clear_bit got=%0b exp=%0b", rx_bit, e.bit_v); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (valid_cnt != snap + 1) begin failures++; $display("FAIL clear_count got=%0d exp=%0d", valid_cnt - snap, 1); end
`ifdef RX_ERR_COUNT_EN
        checks++; if (err_count !== 16'(tb_err)) begin failures++; $display("FAIL clear_err got=%0d exp=%0d", err_count, tb_err); end
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_no_wrap;
        test_tie;
        test_long_level;
        test_reset_flush;
        test_clear;
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
